// File: rtl/sprite_pkg.sv
// Shared sprite-sheet geometry and pixel conventions for the sprite RAM reader and loader.
package sprite_pkg;

    localparam int unsigned SPRITE_COLS    = 34;
    localparam int unsigned SPRITE_ROWS    = 34;
    localparam int unsigned FRAME_COLS     = 3;
    localparam int unsigned FRAME_ROWS     = 8;
    localparam int unsigned MEM_COLS       = SPRITE_COLS * FRAME_COLS;
    localparam int unsigned FRAME_ROW_SIZE = MEM_COLS * SPRITE_ROWS;

    localparam int unsigned PIX_W = 12;
    localparam int unsigned ROW_W = 3;
    localparam int unsigned COL_W = 2;
    localparam int unsigned X_W   = $clog2(SPRITE_COLS);
    localparam int unsigned Y_W   = $clog2(SPRITE_ROWS);

    localparam logic [PIX_W-1:0] TRANSPARENT = 12'h000;
    localparam logic [PIX_W-1:0] BLACK_SUB   = 12'h001;

    typedef logic [PIX_W-1:0] pixel_t;

    // Orientation to frame_row encoding, identical on the reader side.
    typedef enum logic [ROW_W-1:0] {
        DIR_S  = 3'd0,
        DIR_SW = 3'd1,
        DIR_W  = 3'd2,
        DIR_NW = 3'd3,
        DIR_N  = 3'd4,
        DIR_NE = 3'd5,
        DIR_E  = 3'd6,
        DIR_SE = 3'd7
    } dir_e;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } frame_sel_t;

    function automatic logic [ROW_W-1:0] dir_to_row(input dir_e dir);
        return ROW_W'(dir);
    endfunction

    function automatic logic sel_in_range(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
        return (32'(row) < FRAME_ROWS) && (32'(col) < FRAME_COLS);
    endfunction

    // Chroma key becomes transparent; genuine black is nudged so it stays visible.
    function automatic pixel_t map_pixel(input pixel_t pix, input pixel_t key);
        if (pix == key)              return TRANSPARENT;
        else if (pix == TRANSPARENT) return BLACK_SUB;
        else                         return pix;
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Combinational (frame_row, frame_col, x, y) -> sprite RAM address, shared by reader and loader.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int unsigned ADDR_W = 15
) (
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr_c
);

    localparam int unsigned CALC_W = ADDR_W + 4;

    assign addr_c = ADDR_W'(CALC_W'(row) * CALC_W'(FRAME_ROW_SIZE)
                          + CALC_W'(col) * CALC_W'(SPRITE_COLS)
                          + CALC_W'(y)   * CALC_W'(MEM_COLS)
                          + CALC_W'(x));

endmodule

// File: rtl/sprite_ram_loader.sv
// Streams one row-major sprite frame from a valid/ready source into the sprite RAM write port.
module sprite_ram_loader
    import sprite_pkg::*;
#(
    parameter int unsigned      ADDR_W     = 15,
    parameter logic [PIX_W-1:0] CHROMA_KEY = 12'hF0F
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ROW_W-1:0]  frame_row,
    input  logic [COL_W-1:0]  frame_col,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [PIX_W-1:0]  in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    frame_sel_t        sel_q, sel_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    pixel_t            wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept_c;
    logic              last_c;
    logic [ADDR_W-1:0] addr_c;

    sprite_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .row    (sel_q.row),
        .col    (sel_q.col),
        .x      (x_q),
        .y      (y_q),
        .addr_c (addr_c)
    );

    assign accept_c = in_valid && in_ready_q;
    assign last_c   = accept_c && (x_q == X_W'(SPRITE_COLS - 1)) && (y_q == Y_W'(SPRITE_ROWS - 1));

    // Next-state, counters and the single write pipeline stage.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        x_d        = x_q;
        y_d        = y_q;
        in_ready_d = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (accept_c) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_c;
            wr_data_d = map_pixel(in_data, CHROMA_KEY);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (sel_in_range(frame_row, frame_col)) begin
                        sel_d   = '{row: frame_row, col: frame_col};
                        x_d     = '0;
                        y_d     = '0;
                        busy_d  = 1'b1;
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                // First LOAD cycle keeps in_ready low while the new frame base settles.
                busy_d     = 1'b1;
                in_ready_d = 1'b1;
                if (accept_c) begin
                    if (x_q == X_W'(SPRITE_COLS - 1)) begin
                        x_d = '0;
                        y_d = y_q + Y_W'(1);
                    end else begin
                        x_d = x_q + X_W'(1);
                    end
                end
                if (last_c) begin
                    busy_d     = 1'b0;
                    in_ready_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_DONE;
                end else if (abort) begin
                    busy_d     = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            x_q        <= x_d;
            y_q        <= y_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
